// File: rtl/tim_pkg.sv
//------------------------------------------------------------------------------
// Module : tim_pkg
// Brief  : Shared state encoding, V1 levels and register map for tim_vfsm.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package tim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SHUTTER  = 4'd1,
    ST_EXPOSE   = 4'd2,
    ST_FT_SETUP = 4'd3,
    ST_FT       = 4'd4,
    ST_FT_HOLD  = 4'd5,
    ST_LV_A     = 4'd6,
    ST_LV_B     = 4'd7,
    ST_LH       = 4'd8
  } state_t;

  localparam logic [1:0] V1_LOW  = 2'b00;
  localparam logic [1:0] V1_MID  = 2'b01;
  localparam logic [1:0] V1_HIGH = 2'b10;

  localparam logic [1:0] ADDR_LINES_LO = 2'd0;
  localparam logic [1:0] ADDR_LINES_HI = 2'd1;
  localparam logic [1:0] ADDR_EXPOSE   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/tim_vfsm_regs.sv
//------------------------------------------------------------------------------
// Module : tim_vfsm_regs
// Brief  : Write-only configuration registers with per-frame shadow copies.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tim_vfsm_regs
  import tim_pkg::*;
#(
  parameter int         DEF_LINES  = 4,
  parameter int         DEF_EXPOSE = 2,
  parameter logic [7:0] DEF_CTRL   = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_a,
  input  logic [7:0]  i_d,
  input  logic        i_we,
  input  logic        i_latch,
  output logic        o_run,
  output logic        o_shut_en,
  output logic [15:0] o_sh_lines,
  output logic [7:0]  o_sh_expose,
  output logic        o_sh_shut_en
);

  logic [15:0] r_lines;
  logic [7:0]  r_expose;
  // Only the two defined CTRL bits are kept; the rest have no readback path.
  logic [1:0]  r_ctrl;
  logic [15:0] r_sh_lines;
  logic [7:0]  r_sh_expose;
  logic        r_sh_shut_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lines  <= 16'(DEF_LINES);
      r_expose <= 8'(DEF_EXPOSE);
      r_ctrl   <= DEF_CTRL[1:0];
    end else if (i_we) begin
      case (i_a)
        ADDR_LINES_LO: r_lines[7:0]  <= i_d;
        ADDR_LINES_HI: r_lines[15:8] <= i_d;
        ADDR_EXPOSE:   r_expose      <= i_d;
        ADDR_CTRL:     r_ctrl        <= i_d[1:0];
        default:       r_ctrl        <= r_ctrl;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_lines   <= 16'(DEF_LINES);
      r_sh_expose  <= 8'(DEF_EXPOSE);
      r_sh_shut_en <= DEF_CTRL[0];
    end else if (i_latch) begin
      r_sh_lines   <= r_lines;
      r_sh_expose  <= r_expose;
      r_sh_shut_en <= r_ctrl[0];
    end
  end

  assign o_run        = r_ctrl[1];
  assign o_shut_en    = r_ctrl[0];
  assign o_sh_lines   = r_sh_lines;
  assign o_sh_expose  = r_sh_expose;
  assign o_sh_shut_en = r_sh_shut_en;

endmodule

`default_nettype wire

// File: rtl/tim_vfsm.sv
//------------------------------------------------------------------------------
// Module : tim_vfsm
// Brief  : Interline CCD vertical timing: shutter, exposure, transfer, lines.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tim_vfsm
  import tim_pkg::*;
#(
  parameter int         V_STEP     = 30,
  parameter int         FT_PULSE   = 90,
  parameter int         H_ACTIVE   = 60,
  parameter int         SHUT_PULSE = 30,
  parameter int         DEF_LINES  = 4,
  parameter int         DEF_EXPOSE = 2,
  parameter logic [7:0] DEF_CTRL   = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [1:0] a,
  input  logic [7:0] d,
  input  logic       we,
  output logic [1:0] v1,
  output logic       v2,
  output logic       shut,
  output logic       vact
);

  localparam logic [15:0] c_line_clks = 16'(2 * V_STEP + H_ACTIVE);

  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [15:0] r_line_cnt, w_line_cnt_next;
  logic        w_latch, w_done;
  logic        w_run, w_shut_en, w_sh_shut_en;
  logic [15:0] w_sh_lines, w_expose_clks;
  logic [7:0]  w_sh_expose;
  logic [1:0]  w_v1;
  logic        w_v2, w_shut, w_vact;

  tim_vfsm_regs #(
    .DEF_LINES  (DEF_LINES),
    .DEF_EXPOSE (DEF_EXPOSE),
    .DEF_CTRL   (DEF_CTRL)
  ) u_regs (
    .clk          (clk),
    .rst          (rst),
    .i_a          (a),
    .i_d          (d),
    .i_we         (we),
    .i_latch      (w_latch),
    .o_run        (w_run),
    .o_shut_en    (w_shut_en),
    .o_sh_lines   (w_sh_lines),
    .o_sh_expose  (w_sh_expose),
    .o_sh_shut_en (w_sh_shut_en)
  );

  assign w_done        = (r_cnt == 16'd0);
  assign w_expose_clks = {8'd0, w_sh_expose} * c_line_clks;

  // Each state loads len-1 on entry and leaves when the counter reaches zero.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = w_done ? 16'd0 : r_cnt - 16'd1;
    w_line_cnt_next = r_line_cnt;
    w_latch         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (trigger && w_run) begin
          w_latch      = 1'b1;
          w_state_next = ST_SHUTTER;
          w_cnt_next   = 16'(SHUT_PULSE - 1);
        end
      end
      ST_SHUTTER: begin
        if (w_done) begin
          if (w_sh_expose != 8'd0) begin
            w_state_next = ST_EXPOSE;
            w_cnt_next   = w_expose_clks - 16'd1;
          end else begin
            w_state_next = ST_FT_SETUP;
            w_cnt_next   = 16'(V_STEP - 1);
          end
        end
      end
      ST_EXPOSE: begin
        if (w_done) begin
          w_state_next = ST_FT_SETUP;
          w_cnt_next   = 16'(V_STEP - 1);
        end
      end
      ST_FT_SETUP: begin
        if (w_done) begin
          w_state_next = ST_FT;
          w_cnt_next   = 16'(FT_PULSE - 1);
        end
      end
      ST_FT: begin
        if (w_done) begin
          w_state_next = ST_FT_HOLD;
          w_cnt_next   = 16'(V_STEP - 1);
        end
      end
      ST_FT_HOLD: begin
        if (w_done) begin
          if (w_sh_lines == 16'd0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next    = ST_LV_A;
            w_cnt_next      = 16'(V_STEP - 1);
            w_line_cnt_next = w_sh_lines;
          end
        end
      end
      ST_LV_A: begin
        if (w_done) begin
          w_state_next = ST_LV_B;
          w_cnt_next   = 16'(V_STEP - 1);
        end
      end
      ST_LV_B: begin
        if (w_done) begin
          w_state_next = ST_LH;
          w_cnt_next   = 16'(H_ACTIVE - 1);
        end
      end
      ST_LH: begin
        if (w_done) begin
          if (r_line_cnt <= 16'd1) begin
            w_state_next    = ST_IDLE;
            w_line_cnt_next = 16'd0;
          end else begin
            w_state_next    = ST_LV_A;
            w_cnt_next      = 16'(V_STEP - 1);
            w_line_cnt_next = r_line_cnt - 16'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with r_state.
  always_comb begin
    w_v1   = V1_MID;
    w_v2   = 1'b0;
    w_shut = 1'b0;
    w_vact = 1'b0;
    case (w_state_next)
      ST_SHUTTER: w_shut = w_latch ? w_shut_en : w_sh_shut_en;
      ST_FT:      w_v1   = V1_HIGH;
      ST_LV_A: begin
        w_v1 = V1_LOW;
        w_v2 = 1'b1;
      end
      ST_LH:      w_vact = 1'b1;
      default:    w_v1   = V1_MID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 16'd0;
      r_line_cnt <= 16'd0;
      v1         <= V1_MID;
      v2         <= 1'b0;
      shut       <= 1'b0;
      vact       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_line_cnt <= w_line_cnt_next;
      v1         <= w_v1;
      v2         <= w_v2;
      shut       <= w_shut;
      vact       <= w_vact;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tim_vfsm.sv
//------------------------------------------------------------------------------
// Module : tb_tim_vfsm
// Brief  : Directed self-checking bench for tim_vfsm frame timing.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tim_vfsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trigger = 1'b0;
  logic [1:0] a = 2'd0;
  logic [7:0] d = 8'd0;
  logic       we = 1'b0;
  logic [1:0] v1;
  logic       v2, shut, vact;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Edge/run bookkeeping, sampled on the falling edge.
  logic prev_shut = 1'b0, prev_ft = 1'b0, prev_vact = 1'b0, prev_v2 = 1'b0;
  int n_shut = 0, n_ft = 0, n_vact = 0;
  int t_shut_rise = 0, t_ft_rise = 0, t_vact_rise = 0, t_v2_rise = 0;
  int shut_len = 0, ft_len = 0, vact_len = 0, v2_len = 0;
  int shut_period = 0, ft_period = 0;
  int vact_in_frame = 0, vact_prev = 0;
  int t_trig = 0, base = 0;

  tim_vfsm dut (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .a       (a),
    .d       (d),
    .we      (we),
    .v1      (v1),
    .v2      (v2),
    .shut    (shut),
    .vact    (vact)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_shut <= shut;
    prev_ft   <= (v1 == 2'b10);
    prev_vact <= vact;
    prev_v2   <= v2;
    if (shut && !prev_shut) begin
      n_shut      <= n_shut + 1;
      shut_period <= cyc - t_shut_rise;
      t_shut_rise <= cyc;
    end
    if (!shut && prev_shut) shut_len <= cyc - t_shut_rise;
    if ((v1 == 2'b10) && !prev_ft) begin
      n_ft          <= n_ft + 1;
      ft_period     <= cyc - t_ft_rise;
      t_ft_rise     <= cyc;
      vact_prev     <= vact_in_frame;
      vact_in_frame <= 0;
    end
    if ((v1 != 2'b10) && prev_ft) ft_len <= cyc - t_ft_rise;
    if (vact && !prev_vact) begin
      n_vact        <= n_vact + 1;
      vact_in_frame <= vact_in_frame + 1;
      t_vact_rise   <= cyc;
    end
    if (!vact && prev_vact) vact_len <= cyc - t_vact_rise;
    if (v2 && !prev_v2) t_v2_rise <= cyc;
    if (!v2 && prev_v2) v2_len <= cyc - t_v2_rise;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
    a = addr; d = data; we = 1'b1;
    step(1);
    we = 1'b0;
  endtask

  task automatic wait_ft(input int target, input int bound);
    int k = 0;
    while (n_ft < target && k < bound) begin step(1); k++; end
    chk("wait_ft", 32'(n_ft >= target), 32'd1);
  endtask

  task automatic wait_vact(input int target, input int bound);
    int k = 0;
    while (n_vact < target && k < bound) begin step(1); k++; end
    chk("wait_vact", 32'(n_vact >= target), 32'd1);
  endtask

  initial begin
    // Reset levels
    step(3);
    chk("rst_v1", 32'(v1), 32'd1);
    chk("rst_v2", 32'(v2), 32'd0);
    chk("rst_shut", 32'(shut), 32'd0);
    chk("rst_vact", 32'(vact), 32'd0);

    // Default frames, trigger held
    rst = 1'b0; trigger = 1'b1; t_trig = cyc;
    wait_ft(1, 2000);
    chk("shut_delay", 32'(t_shut_rise - t_trig), 32'd1);
    chk("shut_len", 32'(shut_len), 32'd30);
    chk("ft_after_shut", 32'(t_ft_rise - t_shut_rise), 32'd300);
    wait_ft(2, 2000);
    chk("ft_len", 32'(ft_len), 32'd90);
    chk("lines_f1", 32'(vact_prev), 32'd4);
    chk("vact_len", 32'(vact_len), 32'd60);
    chk("v2_len", 32'(v2_len), 32'd30);
    chk("shut_period", 32'(shut_period), 32'd901);
    chk("ft_period", 32'(ft_period), 32'd901);

    // Shutter disabled, then run disabled
    reg_write(2'd3, 8'h02);
    wait_ft(3, 2000);
    chk("noshut_count", 32'(n_shut), 32'd2);
    chk("noshut_period", 32'(ft_period), 32'd901);
    reg_write(2'd3, 8'h00);
    step(1200);
    chk("stop_nft", 32'(n_ft), 32'd3);
    chk("stop_nvact", 32'(n_vact), 32'd12);
    chk("stop_v1", 32'(v1), 32'd1);
    chk("stop_shut", 32'(n_shut), 32'd2);

    // Zero lines and zero exposure
    reg_write(2'd2, 8'h00);
    reg_write(2'd0, 8'h00);
    reg_write(2'd3, 8'h03);
    wait_ft(4, 2000);
    chk("short_ft_delay", 32'(t_ft_rise - t_shut_rise), 32'd60);
    wait_ft(5, 2000);
    chk("short_period", 32'(ft_period), 32'd181);
    chk("short_novact", 32'(vact_prev), 32'd0);
    chk("short_nshut", 32'(n_shut), 32'd4);

    // Mid-frame LINES write only affects the next frame
    trigger = 1'b0;
    step(300);
    reg_write(2'd0, 8'd4);
    base = n_vact;
    trigger = 1'b1;
    wait_vact(base + 2, 2000);
    reg_write(2'd0, 8'd8);
    wait_ft(7, 2000);
    chk("shadow_old_lines", 32'(vact_prev), 32'd4);
    trigger = 1'b0;
    wait_vact(base + 12, 3000);
    step(100);
    chk("shadow_new_lines", 32'(vact_in_frame), 32'd8);
    chk("shadow_nft", 32'(n_ft), 32'd7);

    // Reset during FT restores idle outputs and default registers
    trigger = 1'b1;
    wait_ft(8, 2000);
    step(10);
    chk("pre_rst_v1", 32'(v1), 32'd2);
    rst = 1'b1;
    step(1);
    chk("abort_v1", 32'(v1), 32'd1);
    chk("abort_vact", 32'(vact), 32'd0);
    chk("abort_v2", 32'(v2), 32'd0);
    chk("abort_shut", 32'(shut), 32'd0);
    rst = 1'b0;
    wait_ft(9, 2000);
    chk("def_ft_delay", 32'(t_ft_rise - t_shut_rise), 32'd300);
    wait_ft(10, 2000);
    chk("def_lines", 32'(vact_prev), 32'd4);
    chk("def_period", 32'(ft_period), 32'd901);
    trigger = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
